// File: rtl/alu_mul_div_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_div_seq
//
// Sequential ALU for the EX stage of the multi-cycle datapath. Basic ops
// (AND/OR/ADD/SUB/SLT) finish in one cycle. RV32M multiply/divide/remainder
// ops run on an iterative radix-2 unit: shift-add for MUL*, restoring
// shift-subtract for DIV*/REM*. The unit works on operand magnitudes and
// applies the sign correction in a final FIX cycle.
//
// Build option
//   ALU_MULDIV_EN  defined     : M ops run on the iterative unit
//                               (WIDTH+1 cycles from the start edge to oDone).
//                  not defined : no iterative datapath is built. M op codes
//                               behave like unknown codes (result 0, latency 1)
//                               and oBusy is tied low.
//
// Parameters
//   WIDTH  operand/result width (even, >= 4)
//   CNTW   iteration counter width, derived from WIDTH (do not override)
//
// Ports
//   iCLK      in   1      clock, rising edge
//   iRST      in   1      synchronous active-high reset
//   iStart    in   1      request, sampled only while idle
//   iControl  in   5      op code, sampled with iStart
//   iA, iB    in   WIDTH  operands, sampled with iStart
//   oResult   out  WIDTH  registered result, held until the next completion
//   oBusy     out  1      high while an M op is in flight
//   oDone     out  1      one-cycle completion pulse, oResult valid with it
//
// Op codes
//   AND=0  OR=1  ADD=2  SUB=6  SLT=7
//   MUL=8  MULH=9  MULHSU=10  MULHU=11  DIV=12  DIVU=13  REM=14  REMU=15
//   NULL=31; every other code returns 0
// ---------------------------------------------------------------------------
module alu_mul_div_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [4:0]       iControl,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic [WIDTH-1:0] oResult,
    output logic             oBusy,
    output logic             oDone
);

    localparam logic [4:0] OPAND  = 5'd0;
    localparam logic [4:0] OPOR   = 5'd1;
    localparam logic [4:0] OPADD  = 5'd2;
    localparam logic [4:0] OPSUB  = 5'd6;
    localparam logic [4:0] OPSLT  = 5'd7;

    // Catch a bad parameterisation at elaboration rather than in silicon.
    if (WIDTH < 4 || (WIDTH % 2) != 0 || CNTW != $clog2(WIDTH) + 1) begin : g_param_check
        $error("alu_mul_div_seq: WIDTH must be even and >= 4, CNTW must stay derived");
    end

    // Single-cycle ops, identical to the old combinational ALU.
    logic [WIDTH-1:0] basic_result;

    always_comb begin
        basic_result = '0;
        case (iControl)
            OPAND:   basic_result = iA & iB;
            OPOR:    basic_result = iA | iB;
            OPADD:   basic_result = iA + iB;
            OPSUB:   basic_result = iA - iB;
            OPSLT:   basic_result = {{(WIDTH-1){1'b0}}, ($signed(iA) < $signed(iB))};
            default: basic_result = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN

    localparam logic [4:0] OPMUL    = 5'd8;
    localparam logic [4:0] OPMULH   = 5'd9;
    localparam logic [4:0] OPMULHSU = 5'd10;
    localparam logic [4:0] OPMULHU  = 5'd11;
    localparam logic [4:0] OPDIV    = 5'd12;
    localparam logic [4:0] OPDIVU   = 5'd13;
    localparam logic [4:0] OPREM    = 5'd14;
    localparam logic [4:0] OPREMU   = 5'd15;

    // The first iteration happens on the start edge, so CALC only runs the
    // remaining WIDTH-1 iterations; the counter stops at WIDTH-2.
    localparam logic [CNTW-1:0] LAST_STEP = CNTW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_reg,  state_next;
    logic [4:0]       op_reg,     op_next;
    logic [WIDTH-1:0] hi_reg,     hi_next;     // partial product high half / partial remainder
    logic [WIDTH-1:0] lo_reg,     lo_next;     // multiplier bits / dividend bits becoming quotient
    logic [WIDTH-1:0] mag_reg,    mag_next;    // |multiplicand| or |divisor|
    logic             a_neg_reg,  a_neg_next;
    logic             b_neg_reg,  b_neg_next;
    logic             b_zero_reg, b_zero_next;
    logic [CNTW-1:0]  cnt_reg,    cnt_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             done_reg,   done_next;

    // One radix-2 iteration. Multiply: conditional add of the multiplicand
    // into the high half, then shift {carry, hi, lo} right by one. Divide:
    // shift {rem, dividend} left by one, subtract the divisor, keep the
    // difference only if it did not go negative.
    function automatic logic [2*WIDTH-1:0] iterate(
        input logic             div_mode,
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] mag
    );
        logic [WIDTH:0]   sum;
        logic [WIDTH:0]   shifted;
        logic [WIDTH:0]   trial;
        logic [WIDTH-1:0] hi_n;
        logic [WIDTH-1:0] lo_n;
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, mag} : {(WIDTH+1){1'b0}});
        shifted = {hi, lo[WIDTH-1]};
        trial   = shifted - {1'b0, mag};
        if (div_mode) begin
            // The partial remainder stays below the divisor, so a non-negative
            // trial always fits in WIDTH bits.
            if (!trial[WIDTH]) begin
                hi_n = trial[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = shifted[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo[WIDTH-1:1]};
        end
        return {hi_n, lo_n};
    endfunction

    // Start-edge decode of the incoming request.
    logic             start_mop;
    logic             start_div;
    logic             start_a_signed;
    logic             start_b_signed;
    logic             start_a_neg;
    logic             start_b_neg;
    logic [WIDTH-1:0] start_a_mag;
    logic [WIDTH-1:0] start_b_mag;
    logic [2*WIDTH-1:0] first_step;
    logic [2*WIDTH-1:0] calc_step;

    always_comb begin
        start_mop      = (iControl >= OPMUL) && (iControl <= OPREMU);
        start_div      = (iControl >= OPDIV) && (iControl <= OPREMU);
        start_a_signed = (iControl == OPMULH) || (iControl == OPMULHSU) ||
                         (iControl == OPDIV)  || (iControl == OPREM);
        start_b_signed = (iControl == OPMULH) || (iControl == OPDIV) || (iControl == OPREM);
        start_a_neg    = start_a_signed & iA[WIDTH-1];
        start_b_neg    = start_b_signed & iB[WIDTH-1];
        // |min_int| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit value.
        start_a_mag    = start_a_neg ? (~iA + 1'b1) : iA;
        start_b_mag    = start_b_neg ? (~iB + 1'b1) : iB;
        // Divide: dividend walks through lo, divisor is the magnitude operand.
        // Multiply: multiplier walks through lo, multiplicand is added.
        if (start_div) begin
            first_step = iterate(1'b1, '0, start_a_mag, start_b_mag);
        end else begin
            first_step = iterate(1'b0, '0, start_b_mag, start_a_mag);
        end
    end

    logic               op_is_div;
    logic               prod_neg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_result;

    always_comb begin
        op_is_div = (op_reg >= OPDIV) && (op_reg <= OPREMU);
        calc_step = iterate(op_is_div, hi_reg, lo_reg, mag_reg);
        // Quotient and product share the same sign rule.
        prod_neg  = a_neg_reg ^ b_neg_reg;
        prod_fix  = prod_neg ? (~{hi_reg, lo_reg} + 1'b1) : {hi_reg, lo_reg};
        case (op_reg)
            OPMUL:                      fix_result = prod_fix[WIDTH-1:0];
            OPMULH, OPMULHSU, OPMULHU:  fix_result = prod_fix[2*WIDTH-1:WIDTH];
            // Divide by zero yields all ones whatever the operand signs.
            OPDIV, OPDIVU:              fix_result = b_zero_reg ? '1 : prod_fix[WIDTH-1:0];
            // Remainder takes the sign of the dividend; by zero this
            // reproduces the dividend itself.
            OPREM, OPREMU:              fix_result = a_neg_reg ? (~hi_reg + 1'b1) : hi_reg;
            default:                    fix_result = '0;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        mag_next    = mag_reg;
        a_neg_next  = a_neg_reg;
        b_neg_next  = b_neg_reg;
        b_zero_next = b_zero_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        done_next   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (iStart) begin
                    if (start_mop) begin
                        state_next  = CALC;
                        op_next     = iControl;
                        hi_next     = first_step[2*WIDTH-1:WIDTH];
                        lo_next     = first_step[WIDTH-1:0];
                        mag_next    = start_div ? start_b_mag : start_a_mag;
                        a_neg_next  = start_a_neg;
                        b_neg_next  = start_b_neg;
                        b_zero_next = (iB == '0);
                        cnt_next    = '0;
                    end else begin
                        result_next = basic_result;
                        done_next   = 1'b1;
                    end
                end
            end
            CALC: begin
                hi_next  = calc_step[2*WIDTH-1:WIDTH];
                lo_next  = calc_step[WIDTH-1:0];
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_STEP) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                result_next = fix_result;
                done_next   = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            mag_reg    <= '0;
            a_neg_reg  <= 1'b0;
            b_neg_reg  <= 1'b0;
            b_zero_reg <= 1'b0;
            cnt_reg    <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            mag_reg    <= mag_next;
            a_neg_reg  <= a_neg_next;
            b_neg_reg  <= b_neg_next;
            b_zero_reg <= b_zero_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            done_reg   <= done_next;
        end
    end

    assign oResult = result_reg;
    assign oDone   = done_reg;
    assign oBusy   = (state_reg != IDLE);

`else

    // Basic-only build: every request completes on its start edge.
    logic [WIDTH-1:0] result_reg;
    logic             done_reg;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= iStart;
            if (iStart) begin
                result_reg <= basic_result;
            end
        end
    end

    assign oResult = result_reg;
    assign oDone   = done_reg;
    assign oBusy   = 1'b0;

`endif

endmodule
